// File: rtl/raster_tile_sched.sv
// raster_tile_sched: per-tile triangle issue to raster; RASTER_TRI_CULL_EN enables back-face/degenerate culling
module raster_tile_sched #(
    parameter int TILE_SHIFT  = 5,
    parameter int TILE_COLS   = 20,
    parameter int TILE_ROWS   = 15,
    parameter int TILE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_vld_in,
    output logic        tri_rdy_out,
    input  logic [27:0] tri_v0_in,
    input  logic [27:0] tri_v1_in,
    input  logic [27:0] tri_v2_in,
    input  logic [3:0]  tri_color_in,
    input  logic        tri_last_in,
    output logic        rast_vld_out,
    input  logic        rast_rdy_in,
    output logic [27:0] rast_v0_out,
    output logic [27:0] rast_v1_out,
    output logic [27:0] rast_v2_out,
    output logic [15:0] rast_meta_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [15:0] tile_count_out
);
    localparam int CW = $clog2(TILE_CYCLES);
    localparam logic [9:0] X_LIM = 10'(TILE_COLS << TILE_SHIFT);
    localparam logic [9:0] Y_LIM = 10'(TILE_ROWS << TILE_SHIFT);

    typedef enum logic [2:0] {IDLE, BBOX, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [27:0]   v0, v1, v2;
    logic [3:0]    color;
    logic          last;
    logic [4:0]    tx, tx_min, tx_max;
    logic [3:0]    ty, ty_min, ty_max;
    logic [CW-1:0] cnt;
    logic [15:0]   count;
    logic [9:0]    min_x, max_x, min_y, max_y, max_xc, max_yc;
    logic          drop, tile_end;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = a < b ? a : b;
        return m < c ? m : c;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction

    assign min_x  = min3(v0[27:18], v1[27:18], v2[27:18]);
    assign max_x  = max3(v0[27:18], v1[27:18], v2[27:18]);
    assign min_y  = min3(v0[17:8], v1[17:8], v2[17:8]);
    assign max_y  = max3(v0[17:8], v1[17:8], v2[17:8]);
    assign max_xc = max_x >= X_LIM ? X_LIM - 10'd1 : max_x;
    assign max_yc = max_y >= Y_LIM ? Y_LIM - 10'd1 : max_y;

`ifdef RASTER_TRI_CULL_EN
    logic signed [10:0] dx1, dy1, dx2, dy2;
    logic signed [22:0] area;
    assign dx1  = $signed({1'b0, v1[27:18]}) - $signed({1'b0, v0[27:18]});
    assign dy1  = $signed({1'b0, v1[17:8]}) - $signed({1'b0, v0[17:8]});
    assign dx2  = $signed({1'b0, v2[27:18]}) - $signed({1'b0, v0[27:18]});
    assign dy2  = $signed({1'b0, v2[17:8]}) - $signed({1'b0, v0[17:8]});
    assign area = 23'(dx1) * 23'(dy2) - 23'(dx2) * 23'(dy1);
    assign drop = min_x >= X_LIM || min_y >= Y_LIM || area[22] || area == '0;
`else
    assign drop = min_x >= X_LIM || min_y >= Y_LIM;
`endif

    assign tile_end       = tx == tx_max && ty == ty_max;
    assign rast_v0_out    = v0;
    assign rast_v1_out    = v1;
    assign rast_v2_out    = v2;
    assign rast_meta_out  = {color, 3'b000, ty, tx};
    assign tile_count_out = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        tri_rdy_out    = state == IDLE;
        rast_vld_out   = state == ISSUE;
        busy_out       = state != IDLE;
        frame_done_out = state == DONE;
        case (state)
            IDLE:    state_nxt = tri_vld_in ? BBOX : IDLE;
            BBOX:    state_nxt = drop ? (last ? DONE : IDLE) : ISSUE;
            ISSUE:   state_nxt = rast_rdy_in ? WAIT : ISSUE;
            WAIT:    state_nxt = cnt != '0 ? WAIT : !tile_end ? ISSUE : last ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wait counter is preloaded with TILE_CYCLES-2 so the next issue lands TILE_CYCLES after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v0, v1, v2, color, last} <= '0;
            {tx, tx_min, tx_max, ty, ty_min, ty_max} <= '0;
            cnt   <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && tri_vld_in) begin
                v0    <= tri_v0_in;
                v1    <= tri_v1_in;
                v2    <= tri_v2_in;
                color <= tri_color_in;
                last  <= tri_last_in;
            end
            if (state == BBOX) begin
                tx_min <= 5'(min_x >> TILE_SHIFT);
                tx     <= 5'(min_x >> TILE_SHIFT);
                tx_max <= 5'(max_xc >> TILE_SHIFT);
                ty_min <= 4'(min_y >> TILE_SHIFT);
                ty     <= 4'(min_y >> TILE_SHIFT);
                ty_max <= 4'(max_yc >> TILE_SHIFT);
            end
            if (state == ISSUE && rast_rdy_in) begin
                cnt   <= CW'(TILE_CYCLES - 2);
                count <= count + {15'd0, count != 16'hFFFF};
            end
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    tx <= tx == tx_max ? tx_min : tx + 5'd1;
                    if (tx == tx_max) ty <= ty + 4'd1;
                end
            end
            if (state == DONE) count <= '0;
        end
    end
endmodule

// File: tb/tb_raster_tile_sched.sv
// tb_raster_tile_sched: directed scoreboard bench for raster_tile_sched
module tb_raster_tile_sched;
    localparam int TC = 1024;

    logic        clk = 0, rst = 1;
    logic        tri_vld_in = 0, tri_rdy_out, tri_last_in = 0, rast_vld_out, rast_rdy_in = 1;
    logic [27:0] tri_v0_in = '0, tri_v1_in = '0, tri_v2_in = '0;
    logic [27:0] rast_v0_out, rast_v1_out, rast_v2_out;
    logic [3:0]  tri_color_in = '0;
    logic [15:0] rast_meta_out, tile_count_out;
    logic        busy_out, frame_done_out;

    raster_tile_sched dut (
        .clk(clk), .rst(rst), .tri_vld_in(tri_vld_in), .tri_rdy_out(tri_rdy_out),
        .tri_v0_in(tri_v0_in), .tri_v1_in(tri_v1_in), .tri_v2_in(tri_v2_in),
        .tri_color_in(tri_color_in), .tri_last_in(tri_last_in),
        .rast_vld_out(rast_vld_out), .rast_rdy_in(rast_rdy_in),
        .rast_v0_out(rast_v0_out), .rast_v1_out(rast_v1_out), .rast_v2_out(rast_v2_out),
        .rast_meta_out(rast_meta_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
        .tile_count_out(tile_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, exp_count = 0;
    int n_iss, last_hs, done_cyc, end_cyc;
    logic [83:0] cur_v;
    logic [15:0] q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] meta(input logic [3:0] col, input logic [4:0] x, input logic [3:0] y);
        return {col, 3'b000, y, x};
    endfunction

    task automatic send(input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] bx, input logic [9:0] by,
                        input logic [9:0] cx, input logic [9:0] cy, input logic [3:0] col, input logic lst);
        for (int i = 0; i < 5000 && !tri_rdy_out; i++) tick();
        check("tri_rdy_wait", tri_rdy_out, 1);
        tri_v0_in    = {ax, ay, 8'hA5};
        tri_v1_in    = {bx, by, 8'h3C};
        tri_v2_in    = {cx, cy, 8'h7E};
        cur_v        = {tri_v0_in, tri_v1_in, tri_v2_in};
        tri_color_in = col;
        tri_last_in  = lst;
        tri_vld_in   = 1;
        t0 = cyc;
        tick();
        tri_vld_in   = 0;
    endtask

    task automatic drain();
        int first;
        logic [15:0] e;
        n_iss = 0; last_hs = -1; done_cyc = -1; end_cyc = -1; first = -1;
        rast_rdy_in = 1;
        for (int i = 0; i < 8000; i++) begin
            if (tri_rdy_out) begin
                end_cyc = cyc;
                break;
            end
            if (frame_done_out) begin
                done_cyc = cyc;
                check("done_count", tile_count_out, exp_count);
                if (last_hs >= 0) check("done_gap", cyc - last_hs, TC);
            end
            if (rast_vld_out) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_issue_lat", cyc - t0, 2);
                end
                e = q.size() != 0 ? q.pop_front() : 'x;
                check("issue_meta", rast_meta_out, e);
                check("issue_verts", {rast_v0_out, rast_v1_out, rast_v2_out}, cur_v);
                if (last_hs >= 0) check("issue_gap", cyc - last_hs, TC);
                last_hs = cyc;
                n_iss++;
                exp_count++;
            end
            tick();
        end
        check("drain_end", end_cyc >= 0, 1);
        check("queue_empty", q.size(), 0);
        if (done_cyc >= 0) begin
            check("done_pulse_1cyc", end_cyc - done_cyc, 1);
            check("count_clear", tile_count_out, 0);
            exp_count = 0;
        end
    endtask

    initial begin
        int bad;
        logic [99:0] snap;
        #1;
        check("rst_rdy", tri_rdy_out, 1);
        check("rst_outs", {rast_vld_out, busy_out, frame_done_out, tile_count_out, rast_meta_out}, 0);
        check("rst_verts", {rast_v0_out, rast_v1_out, rast_v2_out}, 0);
        tick(); tick();
        rst = 0;
        tick();

        // 2x2 tile triangle ending the frame
        q.push_back(meta(4'h9, 0, 0)); q.push_back(meta(4'h9, 1, 0));
        q.push_back(meta(4'h9, 0, 1)); q.push_back(meta(4'h9, 1, 1));
        send(10, 10, 40, 10, 10, 40, 4'h9, 1);
        check("bbox_busy", busy_out, 1);
        drain();
        check("t1_issues", n_iss, 4);
        check("t1_done_seen", done_cyc >= 0, 1);

        // fully off-screen, frame end: immediate DONE
        send(650, 10, 700, 20, 800, 30, 4'h2, 1);
        drain();
        check("off_issues", n_iss, 0);
        check("off_done_lat", done_cyc - t0, 2);

        // clamped bottom-right corner, frame continues
        q.push_back(meta(4'h5, 18, 14)); q.push_back(meta(4'h5, 19, 14));
        send(600, 470, 700, 470, 600, 1000, 4'h5, 0);
        drain();
        check("clamp_issues", n_iss, 2);
        check("clamp_rdy_lat", end_cyc - last_hs, TC);
        check("clamp_count", tile_count_out, 2);
        check("clamp_no_done", done_cyc, -1);

        // close frame with an off-screen (y) triangle; total stays 2
        send(10, 500, 20, 600, 30, 700, 4'h1, 1);
        drain();
        check("close_done_lat", done_cyc - t0, 2);

        // stall during first issue, then reset mid-wait
        rast_rdy_in = 0;
        send(10, 10, 40, 10, 10, 40, 4'h3, 1);
        tick();
        check("stall_vld", rast_vld_out, 1);
        snap = {rast_v0_out, rast_v1_out, rast_v2_out, rast_meta_out};
        check("stall_meta0", rast_meta_out, meta(4'h3, 0, 0));
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!rast_vld_out || {rast_v0_out, rast_v1_out, rast_v2_out, rast_meta_out} != snap) bad++;
        end
        check("stall_stable", bad, 0);
        rast_rdy_in = 1;
        tick();
        rast_rdy_in = 0;
        check("stall_count", tile_count_out, 1);
        bad = 0;
        for (int i = 1; i < TC; i++) begin
            if (rast_vld_out) bad++;
            tick();
        end
        check("stall_gap_quiet", bad, 0);
        tick();
        check("stall_next_vld", rast_vld_out, 1);
        check("stall_next_meta", rast_meta_out, meta(4'h3, 1, 0));
        rast_rdy_in = 1;
        tick();
        rast_rdy_in = 0;
        for (int i = 0; i < 300; i++) tick();
        check("midwait_busy", busy_out, 1);
        #2 rst = 1;
        #1;
        check("arst_rdy", tri_rdy_out, 1);
        check("arst_outs", {rast_vld_out, busy_out, frame_done_out, tile_count_out, rast_meta_out}, 0);
        check("arst_verts", {rast_v0_out, rast_v1_out, rast_v2_out}, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (frame_done_out) bad++;
        end
        rst = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (frame_done_out || rast_vld_out) bad++;
        end
        check("arst_no_done", bad, 0);
        exp_count = 0;
        q.delete();

        // clockwise winding: culled only when the cull feature is built in
`ifndef RASTER_TRI_CULL_EN
        q.push_back(meta(4'h7, 0, 0)); q.push_back(meta(4'h7, 1, 0));
        q.push_back(meta(4'h7, 0, 1)); q.push_back(meta(4'h7, 1, 1));
`endif
        send(10, 10, 10, 40, 40, 10, 4'h7, 0);
        drain();
`ifdef RASTER_TRI_CULL_EN
        check("cull_issues", n_iss, 0);
        check("cull_rdy_lat", end_cyc - t0, 2);
`else
        check("nocull_issues", n_iss, 4);
        check("nocull_count", tile_count_out, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/raster_tile_sched.md
# raster_tile_sched

Tile scheduler that sits in front of `raster`. It accepts one screen-space triangle at a time and computes its clamped bounding box in 32×32 tile units. It then issues the triangle once per overlapped tile, in row-major order, using the raster's vertex/metadata handshake. Each issue is spaced by the raster's fixed per-tile processing period, and the block signals frame completion after the last triangle of a frame.

## Interface
- `TILE_SHIFT`, 5: log2 tile width in pixels.
- `TILE_COLS`, 20: tiles per screen row (640 px).
- `TILE_ROWS`, 15: tiles per screen column (480 px).
- `TILE_CYCLES`, 1024: clock cycles the raster spends on one tile.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tri_vld_in` in 1: triangle valid.
- `tri_rdy_out` out 1: scheduler can accept a triangle.
- `tri_v0_in`, `tri_v1_in`, `tri_v2_in` in 28 each: `coord_3d_t` {x[9:0], y[9:0], z[7:0]}, unsigned.
- `tri_color_in` in 4: polygon color.
- `tri_last_in` in 1: this triangle ends the frame.
- `rast_vld_out` out 1: tile job valid to raster.
- `rast_rdy_in` in 1: raster accepts job.
- `rast_v0_out`, `rast_v1_out`, `rast_v2_out` out 28 each: registered copies of the captured vertices.
- `rast_meta_out` out 16: `polygon_t` {color[3:0], padding 3'b0, tile_y[3:0], tile_x[4:0]}.
- `busy_out` out 1: state is not IDLE.
- `frame_done_out` out 1: one-cycle pulse at frame end.
- `tile_count_out` out 16: tiles issued in the current frame, saturating at 16'hFFFF.

## Operation
- **States:** IDLE, BBOX, ISSUE, WAIT, DONE.
- **IDLE:**
  - `tri_rdy_out`=1.
  - On `tri_vld_in`&&`tri_rdy_out`: capture vertices, color and last flag, then go to BBOX.
- **BBOX:** one cycle.
  - Compute min_x/max_x/min_y/max_y over the 3 vertices.
  - Off-screen drop: if min_x≥640 or min_y≥480, go to DONE if last, else IDLE. No tiles are issued.
  - Otherwise clamp max_x to 639 and max_y to 479.
  - Tile bounds: tx_min=min_x>>TILE_SHIFT, tx_max=max_x>>TILE_SHIFT, and likewise for y.
  - Set the current tile to (tx_min, ty_min), then go to ISSUE.
- **ISSUE:**
  - `rast_vld_out`=1 with `rast_meta_out` holding the current tile.
  - All `rast_*` outputs stay stable until `rast_rdy_in`.
  - On handshake: increment `tile_count_out`, load the wait counter, go to WAIT.
- **WAIT:**
  - Count down.
  - On expiry, advance the tile row-major: tx++. When tx>tx_max, wrap tx to tx_min and do ty++.
  - If ty>ty_max, go to DONE if last, else IDLE. Otherwise go to ISSUE.
- **DONE:**
  - `frame_done_out`=1 for exactly one cycle, with `tile_count_out` still showing the frame total.
  - `tile_count_out` clears to 0 on the next edge; state returns to IDLE.
- **Arithmetic:**
  - Bounding box uses unsigned 10-bit compares.
  - Tile indices are 5-bit x and 4-bit y, taken from the clamped values, so tx_max≤19 and ty_max≤14.
- **Reset:**
  - Any state goes to IDLE; the in-flight triangle is discarded and no `frame_done_out` is produced.
  - Reset values: `tri_rdy_out`=1 (IDLE), `rast_vld_out`=0, all `rast_*` data 0, `busy_out`=0, `frame_done_out`=0, `tile_count_out`=0.

## Timing
- Triangle handshake in cycle t0: BBOX in t0+1; first `rast_vld_out` high in t0+2.
- Raster handshake in cycle t: the next `rast_vld_out` rises exactly at cycle t+TILE_CYCLES.
  - The WAIT counter is loaded with TILE_CYCLES−2.
  - WAIT expiry and the ISSUE entry happen on the same edge.
- If `rast_rdy_in` is low, ISSUE stalls indefinitely; the wait period starts only at the handshake.
- After the last tile's WAIT expiry, `tri_rdy_out` rises next cycle (or DONE occupies that cycle first).
- Single-tile triangle: exactly 1 issue, then 1+TILE_CYCLES−1 cycles until return to IDLE.

## Configuration
- `RASTER_TRI_CULL_EN` defined:
  - BBOX additionally computes signed area A=(x1−x0)(y2−y0)−(x2−x0)(y1−y0) using 11-bit signed differences and a 23-bit result.
  - If A≤0, the triangle is dropped exactly like the off-screen case: no tiles issued, and DONE still runs if last.
- Undefined:
  - No area logic.
  - Every on-screen triangle is issued regardless of winding or degeneracy.

## Test plan
- Triangle (10,10),(40,10),(10,40), `rast_rdy_in`=1:
  - 4 issues with meta tile (x,y)=(0,0),(1,0),(0,1),(1,1).
  - Handshakes 1024 cycles apart; `tile_count_out`=4.
- Same triangle with `tri_last_in`=1:
  - `frame_done_out` pulses 1 cycle, 1024 cycles after the 4th handshake, showing `tile_count_out`=4.
  - `tile_count_out` is 0 on the next cycle.
- Triangle (600,470),(700,470),(600,1000):
  - Clamped to tiles x 18..19, y 14 only; 2 issues.
- Triangle with all x≥640 and `tri_last_in`=1:
  - 0 issues; `frame_done_out` at t0+2; `tile_count_out`=0.
- Hold `rast_rdy_in`=0 for 50 cycles during the first ISSUE:
  - `rast_vld_out` and all data stay stable; next issue comes 1024 cycles after the actual handshake.
  - Assert `rst` mid-WAIT: all outputs return to their reset values immediately, with no `frame_done_out`.
- With `RASTER_TRI_CULL_EN`: triangle (10,10),(10,40),(40,10) (A≤0):
  - 0 issues and `tri_rdy_out` high at t0+2.
- Without the macro, the same triangle issues 4 tiles.
